// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - streams program bytes into instruction RAM, then releases the core
module inst_loader #(
    parameter int W = 32,
    parameter int H = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [H:0]   num_words,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    output logic         byte_ready,
    output logic [W-1:0] im_addr,
    output logic [W-1:0] im_inst,
    output logic         is_write,
    output logic         core_run,
    output logic         done,
    output logic [H:0]   words_loaded
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, RUN} state_t;

    localparam logic [H:0] DEPTH = {1'b1, {H{1'b0}}};

    state_t       state_q, state_d;
    logic [H:0]   eff_q, eff_d;
    logic [H:0]   words_q, words_d;
    logic [1:0]   idx_q, idx_d;
    logic [W-1:0] inst_q, inst_d;
    logic [W-1:0] addr_q, addr_d;
    logic         done_q, done_d;
    logic [H:0]   start_eff;
    logic [H:0]   words_inc;

    assign start_eff = (num_words > DEPTH) ? DEPTH : num_words;
    assign words_inc = words_q + {{H{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        eff_d   = eff_q;
        words_d = words_q;
        idx_d   = idx_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    eff_d   = start_eff;
                    words_d = '0;
                    idx_d   = '0;
                    if (start_eff == '0) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (byte_valid) begin
                    inst_d[{idx_q, 3'b000} +: 8] = byte_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = WRITE;
                        // Address is captured here so it stays valid after the count moves on.
                        addr_d = '0;
                        addr_d[H+2:0] = {words_q, 2'b00};
                    end
                end
            end
            WRITE: begin
                words_d = words_inc;
                if (words_inc == eff_q) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else begin
                    state_d = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            eff_q   <= '0;
            words_q <= '0;
            idx_q   <= '0;
            inst_q  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            eff_q   <= eff_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign byte_ready   = (state_q == RECV);
    assign is_write     = (state_q == WRITE);
    assign core_run     = (state_q == RUN);
    assign done         = done_q;
    assign im_addr      = addr_q;
    assign im_inst      = inst_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard bench for inst_loader
module tb_inst_loader;

    localparam int W = 32;
    localparam int H = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [H:0]   num_words;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_ready;
    logic [W-1:0] im_addr;
    logic [W-1:0] im_inst;
    logic         is_write;
    logic         core_run;
    logic         done;
    logic [H:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    inst_loader #(.W(W), .H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .im_addr(im_addr), .im_inst(im_inst), .is_write(is_write),
        .core_run(core_run), .done(done), .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && is_write) begin
            logic [63:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h inst=%h", im_addr, im_inst);
            end else begin
                e = exp_q.pop_front();
                if (im_addr !== e[63:32] || im_inst !== e[31:0] || byte_ready !== 1'b0 || core_run !== 1'b0) begin
                    errors++;
                    $display("FAIL write got addr=%h inst=%h rdy=%b run=%b want addr=%h inst=%h rdy=0 run=0",
                             im_addr, im_inst, byte_ready, core_run, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] inst);
        exp_q.push_back({addr, inst});
    endtask

    task automatic do_start(input logic [H:0] n);
        start = 1'b1;
        num_words = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        byte_valid = 1'b1;
        byte_data = b;
        n = 0;
        while (!byte_ready && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout got=0 want=1");
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] v, input int maxgap);
        for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_is_write"}, 64'(is_write), 64'd0);
        check({tag, "_core_run"}, 64'(core_run), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_im_addr"}, 64'(im_addr), 64'd0);
        check({tag, "_im_inst"}, 64'(im_inst), 64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        start = 1'b0;
        num_words = '0;
        byte_valid = 1'b0;
        byte_data = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Two-word load with exact latency checks.
        expect_write(32'h0, 32'h00000013);
        expect_write(32'h4, 32'h00100093);
        do_start(9'd2);
        check("t1_byte_ready", 64'(byte_ready), 64'd1);
        send_word(32'h00000013, 0);
        send_word(32'h00100093, 0);
        check("t1_is_write_t1", 64'(is_write), 64'd1);
        check("t1_done_early", 64'(done), 64'd0);
        tick();
        check("t1_done", 64'(done), 64'd1);
        check("t1_core_run", 64'(core_run), 64'd1);
        check("t1_words", 64'(words_loaded), 64'd2);
        tick();
        check("t1_done_single", 64'(done), 64'd0);
        check("t1_core_run_hold", 64'(core_run), 64'd1);

        // Zero-length load.
        tick();
        do_start(9'd0);
        check("t2_done", 64'(done), 64'd1);
        check("t2_byte_ready", 64'(byte_ready), 64'd0);
        check("t2_core_run", 64'(core_run), 64'd1);
        check("t2_words", 64'(words_loaded), 64'd0);
        tick();
        check("t2_done_single", 64'(done), 64'd0);

        // Oversized request is clamped to RAM depth.
        for (int i = 0; i < (1 << H); i++) expect_write(32'(i * 4), 32'hA5000000 | 32'(i * 3));
        do_start(9'((1 << H) + 5));
        for (int i = 0; i < (1 << H); i++) send_word(32'hA5000000 | 32'(i * 3), 0);
        tick();
        check("t3_done", 64'(done), 64'd1);
        check("t3_core_run", 64'(core_run), 64'd1);
        check("t3_words", 64'(words_loaded), 64'd256);
        check("t3_last_addr", 64'(im_addr), 64'd1020);
        repeat (3) tick();
        check("t3_run_hold", 64'(core_run), 64'd1);

        // Single word with random byte gaps; bytes offered during WRITE/RUN are ignored.
        expect_write(32'h0, 32'hDEADBEEF);
        do_start(9'd1);
        send_word(32'hDEADBEEF, 3);
        byte_valid = 1'b1;
        byte_data = 8'h77;
        check("t4_ready_in_write", 64'(byte_ready), 64'd0);
        tick();
        check("t4_done", 64'(done), 64'd1);
        tick();
        byte_valid = 1'b0;
        check("t4_inst_hold", 64'(im_inst), 64'hDEADBEEF);
        check("t4_words", 64'(words_loaded), 64'd1);

        // Reset mid-word aborts without writing the partial word.
        expect_write(32'h0, 32'h11111111);
        do_start(9'd3);
        send_word(32'h11111111, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        check_reset_outputs("midrst_hold");
        rst = 1'b0;
        tick();
        expect_write(32'h0, 32'h00000137);
        do_start(9'd1);
        send_word(32'h00000137, 0);
        tick();
        check("t5_done", 64'(done), 64'd1);
        check("t5_words", 64'(words_loaded), 64'd1);

        // start held during RECV is ignored; start in RUN reloads.
        expect_write(32'h0, 32'h44332211);
        expect_write(32'h4, 32'h88776655);
        do_start(9'd2);
        start = 1'b1;
        num_words = 9'd5;
        send_word(32'h44332211, 0);
        send_word(32'h88776655, 0);
        start = 1'b0;
        tick();
        check("t6_done", 64'(done), 64'd1);
        check("t6_words", 64'(words_loaded), 64'd2);
        tick();
        expect_write(32'h0, 32'hCAFEF00D);
        do_start(9'd1);
        check("t6_reload_run_drop", 64'(core_run), 64'd0);
        check("t6_reload_ready", 64'(byte_ready), 64'd1);
        check("t6_reload_words", 64'(words_loaded), 64'd0);
        send_word(32'hCAFEF00D, 1);
        tick();
        check("t6_reload_done", 64'(done), 64'd1);
        check("t6_reload_run", 64'(core_run), 64'd1);

        repeat (2) tick();
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
